// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream framing path in front of the coprocessor.
// Holds the packer write-side FSM state type and the default stream/frame
// constants that are also used by myip_v1_0.
package axis_pkg;

   typedef enum logic {
      PASS = 1'b0,   // forwarding source words into the current frame
      PAD  = 1'b1    // filling the rest of a short frame with zero words
   } pack_state_e;

   localparam int C_AXIS_TDATA_WIDTH    = 32;
   localparam int NUMBER_OF_INPUT_WORDS = 4;
   localparam int FIFO_DEPTH            = 4;

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata : write request and entry; ignored while full (no bypass)
//   pop         : removes the head entry; ignored while empty
//   head        : current head entry, zero while empty
//   full, empty : occupancy flags
module axis_sync_fifo
   import axis_pkg::*;
#(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   // One extra wrap bit tells full from empty when the indices match.
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = empty ? '0 : mem[rptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop_ok)  rptr <= rptr + 1'b1;
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/axis_frame_packer.sv
// Re-frames a raw 32-bit word stream into fixed-length frames of
// NUMBER_OF_INPUT_WORDS words for the coprocessor. Source TLAST only ends a
// frame early; the remainder of such a frame is filled with zero words.
// Ports:
//   ACLK, ARESETN          : clock, asynchronous active-low reset
//   S_AXIS_*               : input stream (TREADY out, TDATA/TLAST/TVALID in)
//   M_AXIS_*               : output stream (TVALID/TDATA/TLAST out, TREADY in)
//   FRAME_COUNT            : frames completed on the output, wrapping
//   PAD_COUNT              : frames that needed padding, saturating at 0xFF
module axis_frame_packer
   import axis_pkg::*;
#(
   parameter int C_AXIS_TDATA_WIDTH    = axis_pkg::C_AXIS_TDATA_WIDTH,
   parameter int NUMBER_OF_INPUT_WORDS = axis_pkg::NUMBER_OF_INPUT_WORDS,
   parameter int FIFO_DEPTH            = axis_pkg::FIFO_DEPTH
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   output logic                          S_AXIS_TREADY,
   input  logic [C_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
   input  logic                          S_AXIS_TLAST,
   input  logic                          S_AXIS_TVALID,
   output logic                          M_AXIS_TVALID,
   output logic [C_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
   output logic                          M_AXIS_TLAST,
   input  logic                          M_AXIS_TREADY,
   output logic [15:0]                   FRAME_COUNT,
   output logic [7:0]                    PAD_COUNT
);

   localparam int WCNT_W = $clog2(NUMBER_OF_INPUT_WORDS);
   localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(NUMBER_OF_INPUT_WORDS - 1);

   pack_state_e                   state;
   logic [WCNT_W-1:0]             wcnt;
   logic                          ready_en;
   logic                          full;
   logic                          empty;
   logic                          push;
   logic                          s_fire;
   logic                          m_fire;
   logic                          tlast_out;
   logic [C_AXIS_TDATA_WIDTH:0]   wdata;
   logic [C_AXIS_TDATA_WIDTH:0]   head;

   // ready_en keeps TREADY low until the first edge after reset release and
   // keeps TREADY free of any combinational path from the inputs.
   assign S_AXIS_TREADY = ready_en && (state == PASS) && !full;
   assign s_fire        = S_AXIS_TVALID && S_AXIS_TREADY;
   assign tlast_out     = (wcnt == WLAST);
   assign push          = (state == PASS) ? s_fire : !full;
   assign wdata         = (state == PASS) ? {tlast_out, S_AXIS_TDATA}
                                          : {tlast_out, {C_AXIS_TDATA_WIDTH{1'b0}}};

   assign M_AXIS_TVALID = !empty;
   assign M_AXIS_TDATA  = head[C_AXIS_TDATA_WIDTH-1:0];
   assign M_AXIS_TLAST  = head[C_AXIS_TDATA_WIDTH];
   assign m_fire        = M_AXIS_TVALID && M_AXIS_TREADY;

   axis_sync_fifo #(
      .WIDTH (C_AXIS_TDATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (ACLK),
      .rst_n (ARESETN),
      .push  (push),
      .wdata (wdata),
      .pop   (m_fire),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state     <= PASS;
         wcnt      <= '0;
         ready_en  <= 1'b0;
         PAD_COUNT <= '0;
      end else begin
         ready_en <= 1'b1;
         if (push) begin
            wcnt <= tlast_out ? '0 : wcnt + 1'b1;
         end
         case (state)
            PASS: begin
               // Source TLAST on the frame's final word closes it normally.
               if (s_fire && S_AXIS_TLAST && !tlast_out) begin
                  state <= PAD;
                  if (PAD_COUNT != 8'hFF) PAD_COUNT <= PAD_COUNT + 8'd1;
               end
            end
            PAD: begin
               if (push && tlast_out) state <= PASS;
            end
            default: state <= PASS;
         endcase
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         FRAME_COUNT <= '0;
      end else if (m_fire && M_AXIS_TLAST) begin
         FRAME_COUNT <= FRAME_COUNT + 16'd1;
      end
   end

endmodule

// File: tb/tb_axis_frame_packer.sv
// Scoreboard bench for axis_frame_packer: stimulus pushes expected output
// words into a queue, a negedge monitor pops and compares on each m_fire.
module tb_axis_frame_packer;

   logic        ACLK;
   logic        ARESETN;
   logic        S_AXIS_TREADY;
   logic [31:0] S_AXIS_TDATA;
   logic        S_AXIS_TLAST;
   logic        S_AXIS_TVALID;
   logic        M_AXIS_TVALID;
   logic [31:0] M_AXIS_TDATA;
   logic        M_AXIS_TLAST;
   logic        M_AXIS_TREADY;
   logic [15:0] FRAME_COUNT;
   logic [7:0]  PAD_COUNT;

   int          checks = 0;
   int          errors = 0;
   logic [32:0] exp_q[$];
   int          mready_mode = 1;   // 0: hold low, 1: hold high, 2: random

   axis_frame_packer dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .S_AXIS_TREADY (S_AXIS_TREADY),
      .S_AXIS_TDATA  (S_AXIS_TDATA),
      .S_AXIS_TLAST  (S_AXIS_TLAST),
      .S_AXIS_TVALID (S_AXIS_TVALID),
      .M_AXIS_TVALID (M_AXIS_TVALID),
      .M_AXIS_TDATA  (M_AXIS_TDATA),
      .M_AXIS_TLAST  (M_AXIS_TLAST),
      .M_AXIS_TREADY (M_AXIS_TREADY),
      .FRAME_COUNT   (FRAME_COUNT),
      .PAD_COUNT     (PAD_COUNT)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Downstream ready driver.
   initial begin
      M_AXIS_TREADY = 1'b1;
      forever begin
         @(posedge ACLK);
         #1;
         case (mready_mode)
            0:       M_AXIS_TREADY = 1'b0;
            1:       M_AXIS_TREADY = 1'b1;
            default: M_AXIS_TREADY = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: compares each accepted output word and checks stall stability.
   initial begin
      logic        prev_stall;
      logic [32:0] prev_word;
      logic [32:0] exp;
      prev_stall = 1'b0;
      prev_word  = '0;
      forever begin
         @(negedge ACLK);
         if (!ARESETN) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall)
               check("stall_hold", {31'd0, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA},
                     {31'd0, 1'b1, prev_word});
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_word", {31'd0, M_AXIS_TLAST, M_AXIS_TDATA}, 64'hDEAD);
               end else begin
                  exp = exp_q.pop_front();
                  check("out_word", {31'd0, M_AXIS_TLAST, M_AXIS_TDATA}, {31'd0, exp});
               end
            end
            prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_word  = {M_AXIS_TLAST, M_AXIS_TDATA};
         end
      end
   end

   task automatic expect_word(input logic [31:0] d, input logic l);
      exp_q.push_back({l, d});
   endtask

   // Called and returns at posedge+1.
   task automatic send(input logic [31:0] d, input logic l);
      bit ok;
      ok = 1'b0;
      S_AXIS_TDATA  = d;
      S_AXIS_TLAST  = l;
      S_AXIS_TVALID = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge ACLK);
         if (S_AXIS_TREADY) ok = 1'b1;
         @(posedge ACLK);
         #1;
      end
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;
      if (!ok) check("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge ACLK);
      check("drain_empty", 64'(exp_q.size()), 64'd0);
      repeat (2) @(posedge ACLK);
      #1;
   endtask

   task automatic do_reset();
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;
      S_AXIS_TDATA  = '0;
      ARESETN       = 1'b0;
      #3;
      check("rst_s_tready", 64'(S_AXIS_TREADY), 64'd0);
      check("rst_m_tvalid", 64'(M_AXIS_TVALID), 64'd0);
      check("rst_m_tdata",  64'(M_AXIS_TDATA),  64'd0);
      check("rst_m_tlast",  64'(M_AXIS_TLAST),  64'd0);
      check("rst_frame_cnt", 64'(FRAME_COUNT),  64'd0);
      check("rst_pad_cnt",  64'(PAD_COUNT),     64'd0);
      exp_q.delete();
      repeat (2) @(posedge ACLK);
      #1;
      ARESETN = 1'b1;
      @(negedge ACLK);
      check("tready_low_before_first_edge", 64'(S_AXIS_TREADY), 64'd0);
      @(posedge ACLK);
      #1;
   endtask

   initial begin
      logic [31:0] a[6];
      int          idx;
      int          low_cycles;
      int          mw;
      int          words;
      int          pads;
      bit          acc;
      logic [31:0] d;
      logic        l;

      ARESETN       = 1'b1;
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;
      S_AXIS_TDATA  = '0;
      #2;

      // 1: two full frames, no source TLAST
      mready_mode = 1;
      do_reset();
      check("tready_after_reset", 64'(S_AXIS_TREADY), 64'd1);
      expect_word(32'h81000, 0); expect_word(32'h46000, 0);
      expect_word(32'h1, 0);     expect_word(32'h2, 1);
      expect_word(32'h3, 0);     expect_word(32'h4, 0);
      expect_word(32'h5, 0);     expect_word(32'h6, 1);
      send(32'h81000, 0); send(32'h46000, 0);
      for (int i = 1; i <= 6; i++) send(32'(i), 0);
      drain();
      check("t1_frame_cnt", 64'(FRAME_COUNT), 64'd2);
      check("t1_pad_cnt",   64'(PAD_COUNT),   64'd0);

      // 2: early TLAST on word 2, padded with two zero words
      do_reset();
      expect_word(32'h81000, 0); expect_word(32'h46000, 0);
      expect_word(32'h0, 0);     expect_word(32'h0, 1);
      send(32'h81000, 0);
      send(32'h46000, 1);
      low_cycles = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge ACLK);
         if (S_AXIS_TREADY) break;
         low_cycles++;
         @(posedge ACLK);
         #1;
      end
      @(posedge ACLK);
      #1;
      check("t2_pad_tready_low_cycles", 64'(low_cycles), 64'd2);
      drain();
      check("t2_pad_cnt",   64'(PAD_COUNT),   64'd1);
      check("t2_frame_cnt", 64'(FRAME_COUNT), 64'd1);

      // 3: backpressure, only FIFO_DEPTH words accepted
      mready_mode = 0;
      do_reset();
      repeat (2) @(posedge ACLK);
      #1;
      a[0] = 32'hA0; a[1] = 32'hA1; a[2] = 32'hA2;
      a[3] = 32'hA3; a[4] = 32'hA4; a[5] = 32'hA5;
      expect_word(a[0], 0); expect_word(a[1], 0); expect_word(a[2], 0);
      expect_word(a[3], 1); expect_word(a[4], 0); expect_word(a[5], 0);
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         S_AXIS_TDATA  = a[idx];
         S_AXIS_TLAST  = 1'b0;
         S_AXIS_TVALID = 1'b1;
         @(negedge ACLK);
         acc = S_AXIS_TREADY;
         @(posedge ACLK);
         #1;
         if (acc) idx++;
      end
      check("t3_accepted", 64'(idx), 64'd4);
      @(negedge ACLK);
      check("t3_tready_full", 64'(S_AXIS_TREADY), 64'd0);
      check("t3_head", {31'd0, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA}, {31'd0, 1'b1, 1'b0, a[0]});
      @(posedge ACLK);
      #1;
      mready_mode = 1;
      send(a[4], 0);
      send(a[5], 0);
      drain();
      check("t3_frame_cnt", 64'(FRAME_COUNT), 64'd1);

      // 4: source TLAST on the frame's last word is not an early end
      do_reset();
      expect_word(32'h10, 0); expect_word(32'h11, 0);
      expect_word(32'h12, 0); expect_word(32'h13, 1);
      expect_word(32'h14, 0); expect_word(32'h15, 0);
      expect_word(32'h16, 0); expect_word(32'h17, 1);
      send(32'h10, 0); send(32'h11, 0); send(32'h12, 0); send(32'h13, 1);
      send(32'h14, 0); send(32'h15, 0); send(32'h16, 0); send(32'h17, 0);
      drain();
      check("t4_pad_cnt",   64'(PAD_COUNT),   64'd0);
      check("t4_frame_cnt", 64'(FRAME_COUNT), 64'd2);

      // 5: reset mid-frame discards buffered words
      mready_mode = 0;
      do_reset();
      repeat (2) @(posedge ACLK);
      #1;
      send(32'hBAD0, 0);
      send(32'hBAD1, 0);
      do_reset();
      mready_mode = 1;
      repeat (2) @(posedge ACLK);
      #1;
      expect_word(32'h20, 0); expect_word(32'h21, 0);
      expect_word(32'h22, 0); expect_word(32'h23, 1);
      send(32'h20, 0); send(32'h21, 0); send(32'h22, 0); send(32'h23, 0);
      drain();
      check("t5_frame_cnt", 64'(FRAME_COUNT), 64'd1);
      check("t5_pad_cnt",   64'(PAD_COUNT),   64'd0);

      // 6: random handshakes with occasional early TLAST
      mready_mode = 2;
      do_reset();
      mw    = 0;
      words = 0;
      pads  = 0;
      for (int n = 0; n < 1000; n++) begin
         repeat ($urandom_range(0, 2)) @(posedge ACLK);
         #0;
         d = $urandom;
         l = ($urandom_range(0, 7) == 0);
         if (l && mw != 3) begin
            expect_word(d, 0);
            words++;
            for (int k = mw + 1; k <= 3; k++) begin
               expect_word(32'h0, k == 3);
               words++;
            end
            mw = 0;
            pads++;
         end else begin
            expect_word(d, mw == 3);
            words++;
            mw = (mw == 3) ? 0 : mw + 1;
         end
         send(d, l);
      end
      mready_mode = 1;
      drain();
      check("t6_frame_cnt", 64'(FRAME_COUNT), 64'(words / 4));
      check("t6_pad_cnt",   64'(PAD_COUNT),   64'(pads));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
